// File: rtl/uart_tx_arbiter_if.sv
// Bundle of request, transmitter and status signals around the UART TX arbiter.
interface uart_tx_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [2*DATA_WIDTH-1:0] ALU_Data;
    logic                    ALU_Valid;
    logic                    ALU_Ready;
    logic [DATA_WIDTH-1:0]   RF_Data;
    logic                    RF_Valid;
    logic                    RF_Ready;
    logic                    TX_Busy;
    logic [DATA_WIDTH-1:0]   TX_P_Data;
    logic                    TX_Data_Valid;
    logic                    Grant;
    logic                    Frame_Done;
    logic                    Arb_Busy;

    modport slave (
        input  ALU_Data, ALU_Valid, RF_Data, RF_Valid, TX_Busy,
        output ALU_Ready, RF_Ready, TX_P_Data, TX_Data_Valid, Grant, Frame_Done, Arb_Busy
    );

    modport master (
        output ALU_Data, ALU_Valid, RF_Data, RF_Valid, TX_Busy,
        input  ALU_Ready, RF_Ready, TX_P_Data, TX_Data_Valid, Grant, Frame_Done, Arb_Busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between the ALU (2-byte)
// and register-file (1-byte) result paths; bytes are paced by TX_Busy.
module uart_tx_arbiter #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned BUSY_TIMEOUT = 4
) (
    input  logic              CLK,
    input  logic              RST,
    uart_tx_arbiter_if.slave  bus
);
    localparam int unsigned BUF_W = 2 * DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    state_t                r_state, w_state_n;
    logic [BUF_W-1:0]      r_buf, w_buf_n;
    logic                  r_two, w_two_n;
    logic                  r_idx, w_idx_n;
    logic [CNT_W-1:0]      r_cnt, w_cnt_n;
    logic                  r_rr, w_rr_n;
    logic                  r_grant, w_grant_n;
    logic [DATA_WIDTH-1:0] r_tx_data, w_tx_data_n;
    logic                  r_tx_valid, w_tx_valid_n;
    logic                  r_alu_ready, w_alu_ready_n;
    logic                  r_rf_ready, w_rf_ready_n;
    logic                  r_frame_done, w_frame_done_n;
    logic                  r_arb_busy;

    logic                  w_pick_rf;
    logic [DATA_WIDTH-1:0] w_cur_byte;
    logic [CNT_W-1:0]      w_cnt_inc;

    // RF wins when it is the only requester or when the pointer favours it.
    assign w_pick_rf  = bus.RF_Valid && (!bus.ALU_Valid || r_rr);
    assign w_cur_byte = r_idx ? r_buf[BUF_W-1:DATA_WIDTH] : r_buf[DATA_WIDTH-1:0];
    assign w_cnt_inc  = r_cnt + CNT_W'(1);

    always_comb begin
        w_state_n      = r_state;
        w_buf_n        = r_buf;
        w_two_n        = r_two;
        w_idx_n        = r_idx;
        w_cnt_n        = r_cnt;
        w_rr_n         = r_rr;
        w_grant_n      = r_grant;
        w_tx_data_n    = r_tx_data;
        w_tx_valid_n   = 1'b0;
        w_alu_ready_n  = 1'b0;
        w_rf_ready_n   = 1'b0;
        w_frame_done_n = 1'b0;

        case (r_state)
            IDLE: begin
                if (!bus.TX_Busy && (bus.ALU_Valid || bus.RF_Valid)) begin
                    w_grant_n = w_pick_rf;
                    w_idx_n   = 1'b0;
                    w_state_n = SEND;
                    if (w_pick_rf) begin
                        w_rf_ready_n = 1'b1;
                        w_buf_n      = {{DATA_WIDTH{1'b0}}, bus.RF_Data};
                        w_two_n      = 1'b0;
                    end else begin
                        w_alu_ready_n = 1'b1;
                        w_buf_n       = bus.ALU_Data;
                        w_two_n       = 1'b1;
                    end
                end
            end
            SEND: begin
                w_tx_data_n  = w_cur_byte;
                w_tx_valid_n = 1'b1;
                w_cnt_n      = '0;
                w_state_n    = WAIT_HI;
            end
            WAIT_HI: begin
                if (bus.TX_Busy) begin
                    w_state_n = WAIT_LO;
                end else begin
                    w_cnt_n = w_cnt_inc;
                    // Transmitter never picked the byte up: strobe it again.
                    if (w_cnt_inc == CNT_W'(BUSY_TIMEOUT)) begin
                        w_state_n = SEND;
                    end
                end
            end
            WAIT_LO: begin
                if (!bus.TX_Busy) begin
                    if (r_two && !r_idx) begin
                        w_idx_n   = 1'b1;
                        w_state_n = SEND;
                    end else begin
                        w_frame_done_n = 1'b1;
                        w_rr_n         = ~r_grant;
                        w_state_n      = IDLE;
                    end
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= IDLE;
            r_buf        <= '0;
            r_two        <= 1'b0;
            r_idx        <= 1'b0;
            r_cnt        <= '0;
            r_rr         <= 1'b0;
            r_grant      <= 1'b0;
            r_tx_data    <= '0;
            r_tx_valid   <= 1'b0;
            r_alu_ready  <= 1'b0;
            r_rf_ready   <= 1'b0;
            r_frame_done <= 1'b0;
            r_arb_busy   <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_buf        <= w_buf_n;
            r_two        <= w_two_n;
            r_idx        <= w_idx_n;
            r_cnt        <= w_cnt_n;
            r_rr         <= w_rr_n;
            r_grant      <= w_grant_n;
            r_tx_data    <= w_tx_data_n;
            r_tx_valid   <= w_tx_valid_n;
            r_alu_ready  <= w_alu_ready_n;
            r_rf_ready   <= w_rf_ready_n;
            r_frame_done <= w_frame_done_n;
            r_arb_busy   <= (w_state_n != IDLE);
        end
    end

    assign bus.ALU_Ready     = r_alu_ready;
    assign bus.RF_Ready      = r_rf_ready;
    assign bus.TX_P_Data     = r_tx_data;
    assign bus.TX_Data_Valid = r_tx_valid;
    assign bus.Grant         = r_grant;
    assign bus.Frame_Done    = r_frame_done;
    assign bus.Arb_Busy      = r_arb_busy;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a simple busy-flag transmitter model.
module tb_uart_tx_arbiter;
    logic CLK = 1'b0;
    logic RST = 1'b1;

    uart_tx_arbiter_if #(.DATA_WIDTH(8)) bus ();

    uart_tx_arbiter #(.DATA_WIDTH(8), .BUSY_TIMEOUT(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;
    int fd_seen  = 0;

    logic [8:0] q_byte[$];   // {grant, data}
    logic       q_grant[$];

    // Transmitter model: 0 = busy 10 cycles starting the cycle after a strobe,
    // 1 = busy never rises, 2 = busy driven by the stimulus directly.
    int   mode = 0;
    logic manual_busy = 1'b0;
    logic model_busy = 1'b0;
    assign bus.TX_Busy = (mode == 2) ? manual_busy : model_busy;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    endtask

    initial begin : tx_model
        int  cnt;
        bit  pend;
        cnt  = 0;
        pend = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            if (mode == 0) begin
                if (pend) cnt = 10;
                model_busy = (cnt > 0);
                if (cnt > 0) cnt--;
                pend = bus.TX_Data_Valid;
            end else begin
                cnt        = 0;
                pend       = 1'b0;
                model_busy = 1'b0;
            end
        end
    end

    initial begin : monitor
        logic [8:0] e;
        logic       g;
        forever begin
            @(negedge CLK);
            if (RST !== 1'b0) continue;
            if (bus.TX_Data_Valid) begin
                chk("tx_byte_expected", 32'(q_byte.size() > 0), 32'd1);
                if (q_byte.size() > 0) begin
                    e = q_byte.pop_front();
                    chk("tx_byte", 32'(bus.TX_P_Data), 32'(e[7:0]));
                    chk("tx_grant", 32'(bus.Grant), 32'(e[8]));
                    chk("tx_busy_low_at_strobe", 32'(bus.TX_Busy), 32'd0);
                end
            end
            if (bus.ALU_Ready || bus.RF_Ready) begin
                chk("ready_expected", 32'(q_grant.size() > 0), 32'd1);
                if (q_grant.size() > 0) begin
                    g = q_grant.pop_front();
                    chk("ready_src", 32'({bus.ALU_Ready, bus.RF_Ready}), g ? 32'd1 : 32'd2);
                    chk("grant_at_ready", 32'(bus.Grant), 32'(g));
                end
            end
            if (bus.Frame_Done) begin
                fd_seen++;
                chk("fd_after_busy_low", 32'(bus.TX_Busy), 32'd0);
                chk("fd_arb_idle", 32'(bus.Arb_Busy), 32'd0);
            end
        end
    end

    function automatic logic sel(input int which);
        case (which)
            0:       return bus.ALU_Ready;
            1:       return bus.RF_Ready;
            2:       return bus.TX_Data_Valid;
            3:       return bus.Frame_Done;
            default: return bus.ALU_Ready | bus.RF_Ready;
        endcase
    endfunction

    // Waits up to budget negedges for the selected strobe; n = negedges waited.
    task automatic wait_chk(input string nm, input int which, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge CLK);
            if (sel(which)) begin
                n = i;
                break;
            end
        end
        chk({nm, "_seen"}, 32'(n > 0), 32'd1);
    endtask

    task automatic check_reset_outs(input string nm);
        chk(nm, 32'({bus.TX_P_Data, bus.TX_Data_Valid, bus.Grant, bus.Frame_Done,
                     bus.Arb_Busy, bus.ALU_Ready, bus.RF_Ready}), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n, fd0;
        bit seen;
        bus.ALU_Data  = '0;
        bus.ALU_Valid = 1'b0;
        bus.RF_Data   = '0;
        bus.RF_Valid  = 1'b0;
        repeat (3) @(negedge CLK);
        check_reset_outs("reset_outputs");
        RST = 1'b0;

        // Single RF frame
        fd0 = fd_seen;
        q_grant.push_back(1'b1);
        q_byte.push_back({1'b1, 8'hA5});
        bus.RF_Data  = 8'hA5;
        bus.RF_Valid = 1'b1;
        wait_chk("t1_ready", 1, 10, n);
        chk("t1_ready_latency", 32'(n), 32'd1);
        bus.RF_Valid = 1'b0;
        wait_chk("t1_txv", 2, 10, n);
        chk("t1_txv_latency", 32'(n), 32'd1);
        wait_chk("t1_fd", 3, 40, n);
        chk("t1_fd_count", 32'(fd_seen - fd0), 32'd1);
        chk("t1_grant", 32'(bus.Grant), 32'd1);

        // Single ALU frame, low byte first
        do_reset();
        fd0 = fd_seen;
        q_grant.push_back(1'b0);
        q_byte.push_back({1'b0, 8'h34});
        q_byte.push_back({1'b0, 8'h12});
        bus.ALU_Data  = 16'h1234;
        bus.ALU_Valid = 1'b1;
        wait_chk("t2_ready", 0, 10, n);
        bus.ALU_Valid = 1'b0;
        wait_chk("t2_txv0", 2, 10, n);
        wait_chk("t2_txv1", 2, 30, n);
        chk("t2_byte_gap", 32'(n), 32'd13);
        wait_chk("t2_fd", 3, 40, n);
        chk("t2_fd_count", 32'(fd_seen - fd0), 32'd1);

        // Both requesting for three frames: ALU, RF, ALU
        do_reset();
        fd0 = fd_seen;
        q_grant.push_back(1'b0);
        q_grant.push_back(1'b1);
        q_grant.push_back(1'b0);
        q_byte.push_back({1'b0, 8'hEF});
        q_byte.push_back({1'b0, 8'hBE});
        q_byte.push_back({1'b1, 8'h5A});
        q_byte.push_back({1'b0, 8'hEF});
        q_byte.push_back({1'b0, 8'hBE});
        bus.ALU_Data  = 16'hBEEF;
        bus.RF_Data   = 8'h5A;
        bus.ALU_Valid = 1'b1;
        bus.RF_Valid  = 1'b1;
        for (int k = 0; k < 3; k++) wait_chk("t3_ready", 4, 80, n);
        bus.ALU_Valid = 1'b0;
        bus.RF_Valid  = 1'b0;
        wait_chk("t3_fd_last", 3, 80, n);
        chk("t3_fd_count", 32'(fd_seen - fd0), 32'd3);

        // Busy never rises: same byte re-strobed every 5 cycles
        do_reset();
        fd0 = fd_seen;
        mode = 1;
        q_grant.push_back(1'b1);
        for (int k = 0; k < 3; k++) q_byte.push_back({1'b1, 8'h77});
        bus.RF_Data  = 8'h77;
        bus.RF_Valid = 1'b1;
        wait_chk("t4_ready", 1, 10, n);
        bus.RF_Valid = 1'b0;
        wait_chk("t4_txv0", 2, 10, n);
        wait_chk("t4_txv1", 2, 20, n);
        chk("t4_retry_gap1", 32'(n), 32'd5);
        wait_chk("t4_txv2", 2, 20, n);
        chk("t4_retry_gap2", 32'(n), 32'd5);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("t4_no_fd", 32'(fd_seen - fd0), 32'd0);
        mode = 0;

        // Reset in WAIT_LO of the first ALU byte; pending RF wins afterwards
        do_reset();
        fd0 = fd_seen;
        q_grant.push_back(1'b0);
        q_byte.push_back({1'b0, 8'h34});
        q_grant.push_back(1'b1);
        q_byte.push_back({1'b1, 8'hC3});
        bus.ALU_Data  = 16'h1234;
        bus.ALU_Valid = 1'b1;
        wait_chk("t5_alu_ready", 0, 10, n);
        bus.ALU_Valid = 1'b0;
        bus.RF_Data   = 8'hC3;
        bus.RF_Valid  = 1'b1;
        wait_chk("t5_txv0", 2, 10, n);
        repeat (3) @(negedge CLK);
        chk("t5_in_wait_lo", 32'({bus.Arb_Busy, bus.TX_Busy}), 32'd3);
        RST = 1'b1;
        @(negedge CLK);
        check_reset_outs("t5_reset_outputs");
        RST = 1'b0;
        wait_chk("t5_rf_ready", 1, 30, n);
        bus.RF_Valid = 1'b0;
        wait_chk("t5_fd", 3, 40, n);
        chk("t5_fd_count", 32'(fd_seen - fd0), 32'd1);
        chk("t5_grant", 32'(bus.Grant), 32'd1);

        // Busy high in IDLE holds off the grant
        do_reset();
        fd0 = fd_seen;
        mode = 2;
        manual_busy = 1'b1;
        q_grant.push_back(1'b1);
        q_byte.push_back({1'b1, 8'h3C});
        bus.RF_Data  = 8'h3C;
        bus.RF_Valid = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            seen |= bus.RF_Ready;
        end
        chk("t6_no_ready_while_busy", 32'(seen), 32'd0);
        manual_busy = 1'b0;
        wait_chk("t6_ready", 1, 5, n);
        chk("t6_ready_latency", 32'(n), 32'd1);
        mode = 0;
        bus.RF_Valid = 1'b0;
        wait_chk("t6_fd", 3, 40, n);
        chk("t6_fd_count", 32'(fd_seen - fd0), 32'd1);

        repeat (5) @(negedge CLK);
        chk("queues_drained", 32'(q_byte.size() + q_grant.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between two requesters: the ALU result path (16-bit, sent as two bytes) and the register-file read path (8-bit, one byte).
- Accepts one frame at a time via valid/ready and latches it.
- Issues bytes to the transmitter as single-cycle data-valid pulses, paced by the transmitter busy flag.
- Sits between the system controller outputs and the UART transmitter, in the transmitter's clock domain.

Parameters:
- DATA_WIDTH, 8, width of one transmitted byte.
- BUSY_TIMEOUT, 4, max cycles to wait for TX_Busy to rise after a valid pulse before re-issuing the byte.

Ports:
- CLK, input, 1, transmitter clock.
- RST, input, 1, synchronous active-high reset.
- ALU_Data, input, 2*DATA_WIDTH, ALU result; low byte is transmitted first.
- ALU_Valid, input, 1, ALU frame request.
- ALU_Ready, output, 1, ALU frame accepted this cycle (1-cycle pulse).
- RF_Data, input, DATA_WIDTH, register-file read data.
- RF_Valid, input, 1, register-file frame request.
- RF_Ready, output, 1, RF frame accepted this cycle (1-cycle pulse).
- TX_Busy, input, 1, transmitter busy flag.
- TX_P_Data, output, DATA_WIDTH, byte presented to the transmitter.
- TX_Data_Valid, output, 1, 1-cycle byte strobe to the transmitter.
- Grant, output, 1, source of the current or last frame (0 = ALU, 1 = RF).
- Frame_Done, output, 1, 1-cycle pulse when the last byte's transmission ends.
- Arb_Busy, output, 1, high whenever the state is not IDLE.

Behaviour:
- Reset (synchronous, RST=1 at a CLK edge) puts every output to 0, including TX_P_Data, Grant, Frame_Done and the Ready signals.
  - Reset also clears: state to IDLE, round-robin pointer to 0 (ALU favoured next), byte index, timeout counter.
  - Reset mid-frame abandons the frame; no Frame_Done is produced.
- States: IDLE, SEND, WAIT_HI, WAIT_LO.
- IDLE:
  - Waits while TX_Busy=1.
  - With TX_Busy=0 and at least one Valid, grants the frame.
  - Both Valid high: grant goes to the source not granted last (round robin). Only one Valid high: that source wins.
  - On grant:
    - Pulse the granted Ready for 1 cycle.
    - Latch the data (ALU: 2 bytes; RF: 1 byte).
    - Set Grant, set byte index to 0, go to SEND.
- SEND:
  - Drive TX_P_Data with the current byte and assert TX_Data_Valid for exactly 1 cycle.
  - Clear the timeout counter and go to WAIT_HI.
  - TX_P_Data holds its value until the next SEND.
- WAIT_HI:
  - TX_Busy=1: go to WAIT_LO.
  - Otherwise increment the counter. When it reaches BUSY_TIMEOUT, return to SEND and re-issue the same byte (retries are unbounded).
- WAIT_LO:
  - Wait for TX_Busy=0.
  - More bytes remain: increment byte index, go to SEND.
  - Last byte done: pulse Frame_Done, update the round-robin pointer to point away from Grant, go to IDLE.
- Spacing: minimum 1 idle cycle between the transmitter dropping busy and the next TX_Data_Valid (the WAIT_LO→SEND transition).
- Latency: Valid at cycle N with the arbiter idle gives Ready at N+1 and TX_Data_Valid at N+2.
- Requests arriving during a frame are not accepted. Valid must be held until Ready; both Valids are sampled only in IDLE.
- Valid deasserted before Ready means no grant. Data is sampled only on the Ready cycle.
- Arb_Busy = (state != IDLE).

Test Plan:
- Single RF frame: RF_Data=0xA5, RF_Valid=1; model busy as rising 1 cycle after valid and staying high 10 cycles → one TX_Data_Valid with 0xA5, RF_Ready pulse, Frame_Done once after busy falls, Grant=1.
- Single ALU frame: ALU_Data=0x1234 → TX_P_Data 0x34 then 0x12, two valid pulses, each issued only after busy falls; one Frame_Done.
- Simultaneous requests, both held high for 3 frames: ALU=0xBEEF, RF=0x5A → grant order ALU, RF, ALU; no back-to-back grants to the same source.
- Busy never rises: TX_Busy held 0 → TX_Data_Valid re-pulses every BUSY_TIMEOUT+1 = 5 cycles with the same byte; no Frame_Done.
- RST=1 during WAIT_LO of the first ALU byte → next cycle all outputs 0, state IDLE, no second byte, no Frame_Done. A pending RF request is granted afterwards (pointer reset to 0, ALU not requesting).
- TX_Busy=1 in IDLE with RF_Valid=1 → no RF_Ready until TX_Busy=0; then grant on the next cycle.
